// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input, and decoder handshake.
interface instruction_fetch_if #(
   parameter int unsigned ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_en;
   logic [15:0]           mem_dout;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic [15:0]           instr;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  instr_valid;
   logic                  instr_ready;

   modport master (
      output mem_addr, mem_rd_en, instr, instr_pc, instr_valid,
      input  mem_dout, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  mem_addr, mem_rd_en, instr, instr_pc, instr_valid,
      output mem_dout, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, synchronous memory read issue, output buffer with valid/ready.
// Define FETCH_SKID_EN for a two-entry buffer sustaining one instruction per cycle.
module instruction_fetch #(
   parameter int unsigned          ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                clk,
   input  logic                reset,
   instruction_fetch_if.master bus
);

   typedef struct packed {
      logic [15:0]           data;
      logic [ADDR_WIDTH-1:0] pc;
   } entry_t;

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   entry_t                head_q, head_d;
   logic                  head_vld_q, head_vld_d;
`ifdef FETCH_SKID_EN
   entry_t                skid_q, skid_d;
   logic                  skid_vld_q, skid_vld_d;
   logic [1:0]            occupancy;
   logic [2:0]            pending;
`endif

   logic   pop;
   logic   issue;
   entry_t ret_entry;

   assign pop       = head_vld_q && bus.instr_ready;
   assign ret_entry = '{data: bus.mem_dout, pc: inflight_pc_q};

`ifdef FETCH_SKID_EN
   // Count the word still in flight so a stalled consumer never loses a returning read.
   assign occupancy = {1'b0, head_vld_q} + {1'b0, skid_vld_q};
   assign pending   = 3'(occupancy) + 3'(inflight_q) - 3'(pop);
   assign issue     = !reset && !bus.redirect && (pending < 3'd2);
`else
   assign issue     = !reset && !bus.redirect && !inflight_q && (!head_vld_q || pop);
`endif

   always_comb begin
      bus.mem_addr    = pc_q;
      bus.mem_rd_en   = issue;
      bus.instr       = head_q.data;
      bus.instr_pc    = head_q.pc;
      bus.instr_valid = head_vld_q;
   end

   always_comb begin
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = issue;
      head_d        = head_q;
      head_vld_d    = head_vld_q;
`ifdef FETCH_SKID_EN
      skid_d        = skid_q;
      skid_vld_d    = skid_vld_q;
`endif

      if (issue) begin
         pc_d          = pc_q + ADDR_WIDTH'(1);
         inflight_pc_d = pc_q;
      end

`ifdef FETCH_SKID_EN
      if (pop) begin
         if (skid_vld_q) begin
            head_d = skid_q;
         end
         head_vld_d = skid_vld_q;
         skid_vld_d = 1'b0;
      end
      // Returned word goes to the first free slot after this cycle's pop.
      if (inflight_q) begin
         if (!head_vld_d) begin
            head_d     = ret_entry;
            head_vld_d = 1'b1;
         end else begin
            skid_d     = ret_entry;
            skid_vld_d = 1'b1;
         end
      end
`else
      if (pop) begin
         head_vld_d = 1'b0;
      end
      if (inflight_q) begin
         head_d     = ret_entry;
         head_vld_d = 1'b1;
      end
`endif

      // Redirect squashes buffered and in-flight words; the returning word is dropped.
      if (bus.redirect) begin
         pc_d       = bus.redirect_pc;
         inflight_d = 1'b0;
         head_vld_d = 1'b0;
`ifdef FETCH_SKID_EN
         skid_vld_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         head_q        <= '0;
         head_vld_q    <= 1'b0;
`ifdef FETCH_SKID_EN
         skid_q        <= '0;
         skid_vld_q    <= 1'b0;
`endif
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         head_q        <= head_d;
         head_vld_q    <= head_vld_d;
`ifdef FETCH_SKID_EN
         skid_q        <= skid_d;
         skid_vld_q    <= skid_vld_d;
`endif
      end
   end

   hold_while_stalled: assert property (@(posedge clk) disable iff (reset)
      (bus.instr_valid && !bus.instr_ready && !bus.redirect) |=>
      (bus.instr_valid && $stable(bus.instr) && $stable(bus.instr_pc)));

   no_issue_on_redirect: assert property (@(posedge clk) disable iff (reset)
      bus.redirect |-> !bus.mem_rd_en);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: stream-order model plus directed literal checks.
module tb_instruction_fetch;
   localparam int unsigned AW = 16;
`ifdef FETCH_SKID_EN
   localparam int LIMIT = 2;
`else
   localparam int LIMIT = 1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instruction_fetch_if #(.ADDR_WIDTH(AW)) bus ();
   instruction_fetch_if #(.ADDR_WIDTH(AW)) wbus ();

   instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(16'h0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(16'hFFFE)) dut_w (
      .clk   (clk),
      .reset (reset),
      .bus   (wbus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int req10 = 0;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h0000;
         16'h0001: return 16'h5102;
         16'h0002: return 16'h0351;
         16'h0003: return 16'hC405;
         default:  return a ^ 16'hB6C3;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Synchronous instruction memories: data appears the cycle after the request.
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_dout <= mem_word(bus.mem_addr);
      if (wbus.mem_rd_en) wbus.mem_dout <= mem_word(wbus.mem_addr);
   end

   // Stream model: words leave in program order from the last reset/redirect target;
   // the next request address is the next expected word plus the words already issued.
   initial begin
      logic [15:0] exp_pc, prev_instr, prev_pc;
      logic        prev_valid, prev_ready, prev_redirect;
      int          outstanding;
      exp_pc = 16'h0; outstanding = 0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_redirect = 1'b0;
      prev_instr = 16'h0; prev_pc = 16'h0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_pc = 16'h0; outstanding = 0;
            prev_valid = 1'b0; prev_ready = 1'b0; prev_redirect = 1'b0;
         end else begin
            if (bus.mem_rd_en && bus.mem_addr == 16'h0010) req10++;
            if (bus.instr_valid) begin
               chk("stream_pc", 32'(bus.instr_pc), 32'(exp_pc));
               chk("stream_data", 32'(bus.instr), 32'(mem_word(bus.instr_pc)));
            end
            if (prev_valid && !prev_ready && !prev_redirect) begin
               chk("hold_valid", 32'(bus.instr_valid), 32'd1);
               chk("hold_instr", 32'(bus.instr), 32'(prev_instr));
               chk("hold_pc", 32'(bus.instr_pc), 32'(prev_pc));
            end
            if (bus.redirect) chk("redirect_no_issue", 32'(bus.mem_rd_en), 32'd0);
            if (bus.mem_rd_en)
               chk("req_addr", 32'(bus.mem_addr), 32'(exp_pc + 16'(outstanding)));
            if (bus.redirect) begin
               exp_pc = bus.redirect_pc;
               outstanding = 0;
            end else begin
               if (bus.mem_rd_en) outstanding++;
               if (bus.instr_valid && bus.instr_ready) begin
                  exp_pc = exp_pc + 16'd1;
                  outstanding--;
               end
               chk("words_held_bound", 32'(outstanding <= LIMIT), 32'd1);
            end
            prev_valid    = bus.instr_valid;
            prev_ready    = bus.instr_ready;
            prev_redirect = bus.redirect;
            prev_instr    = bus.instr;
            prev_pc       = bus.instr_pc;
         end
      end
   end

   logic [15:0] wcap_pc[$];
   logic [15:0] wcap_dat[$];
   initial forever begin
      @(negedge clk);
      if (!reset && wbus.instr_valid && wbus.instr_ready && wcap_pc.size() < 4) begin
         wcap_pc.push_back(wbus.instr_pc);
         wcap_dat.push_back(wbus.instr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_valid(input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.instr_valid) begin
            found = 1'b1;
            break;
         end
      end
      chk(name, 32'(found), 32'd1);
   endtask

   initial begin
      logic [15:0] lit_word[4];
      logic [15:0] held_pc;
      int          base10;
      lit_word[0] = 16'h0000; lit_word[1] = 16'h5102;
      lit_word[2] = 16'h0351; lit_word[3] = 16'hC405;
`ifdef FETCH_SKID_EN
      held_pc = 16'h0008;
`else
      held_pc = 16'h0004;
`endif
      bus.instr_ready = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = 16'h0;
      wbus.instr_ready = 1'b1; wbus.redirect = 1'b0; wbus.redirect_pc = 16'h0;

      // Reset state
      run(2);
      settle();
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
      chk("rst_instr", 32'(bus.instr), 32'h0);
      chk("rst_instr_pc", 32'(bus.instr_pc), 32'h0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);

      // Release: first request in cycle 0, first word valid in cycle 2
      tick(); reset = 1'b0;
      settle();
      chk("first_rd_en", 32'(bus.mem_rd_en), 32'd1);
      chk("first_addr", 32'(bus.mem_addr), 32'h0);
      tick(); settle();
      chk("c1_valid", 32'(bus.instr_valid), 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick(); settle();
`ifdef FETCH_SKID_EN
         chk("seq_valid", 32'(bus.instr_valid), 32'd1);
         if (k < 4) begin
            chk("seq_pc", 32'(bus.instr_pc), 32'(k));
            chk("seq_word", 32'(bus.instr), 32'(lit_word[k]));
         end
`else
         if (k % 2 == 0) begin
            chk("seq_valid", 32'(bus.instr_valid), 32'd1);
            chk("seq_pc", 32'(bus.instr_pc), 32'(k / 2));
            chk("seq_word", 32'(bus.instr), 32'(lit_word[k / 2]));
         end else begin
            chk("seq_gap", 32'(bus.instr_valid), 32'd0);
         end
`endif
      end

      // Wrap instance started at FFFE
      chk("wrap_count", 32'(wcap_pc.size()), 32'd4);
      if (wcap_pc.size() == 4) begin
         chk("wrap_pc0", 32'(wcap_pc[0]), 32'hFFFE);
         chk("wrap_pc1", 32'(wcap_pc[1]), 32'hFFFF);
         chk("wrap_pc2", 32'(wcap_pc[2]), 32'h0000);
         chk("wrap_pc3", 32'(wcap_pc[3]), 32'h0001);
         chk("wrap_dat0", 32'(wcap_dat[0]), 32'(16'hFFFE ^ 16'hB6C3));
         chk("wrap_dat3", 32'(wcap_dat[3]), 32'h5102);
      end

      // Stall for five cycles
      for (int s = 0; s < 5; s++) begin
         tick(); bus.instr_ready = 1'b0;
         settle();
         chk("stall_valid", 32'(bus.instr_valid), 32'd1);
         chk("stall_pc", 32'(bus.instr_pc), 32'(held_pc));
         if (s >= 2) chk("stall_no_issue", 32'(bus.mem_rd_en), 32'd0);
      end
      tick(); bus.instr_ready = 1'b1;
      settle();
      chk("resume_pc", 32'(bus.instr_pc), 32'(held_pc));
      run(6);

      // Redirect to 0x0040 with a word in flight and the consumer stalled
      tick(); bus.instr_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
      settle();
      tick(); bus.redirect = 1'b0; bus.instr_ready = 1'b1;
      settle();
      chk("redir_t1_valid", 32'(bus.instr_valid), 32'd0);
      chk("redir_t1_rd_en", 32'(bus.mem_rd_en), 32'd1);
      chk("redir_t1_addr", 32'(bus.mem_addr), 32'h0040);
      tick(); settle();
      chk("redir_t2_valid", 32'(bus.instr_valid), 32'd0);
      tick(); settle();
      chk("redir_t3_valid", 32'(bus.instr_valid), 32'd1);
      chk("redir_t3_pc", 32'(bus.instr_pc), 32'h0040);
      chk("redir_t3_word", 32'(bus.instr), 32'(16'h0040 ^ 16'hB6C3));
      run(6);

      // Back-to-back redirects 0x10 then 0x20, first one with a transfer
      wait_valid("wait_valid_redir2");
      base10 = req10;
      bus.redirect = 1'b1; bus.redirect_pc = 16'h0010;
      settle();
      chk("redir2_xfer", 32'(bus.instr_valid && bus.instr_ready), 32'd1);
      tick(); bus.redirect_pc = 16'h0020;
      settle();
      tick(); bus.redirect = 1'b0;
      settle();
      chk("redir2_rd_en", 32'(bus.mem_rd_en), 32'd1);
      chk("redir2_addr", 32'(bus.mem_addr), 32'h0020);
      tick(); settle();
      chk("redir2_gap", 32'(bus.instr_valid), 32'd0);
      tick(); settle();
      chk("redir2_valid", 32'(bus.instr_valid), 32'd1);
      chk("redir2_pc", 32'(bus.instr_pc), 32'h0020);
      run(6);
      chk("no_0x10_request", 32'(req10 - base10), 32'd0);

      // Reset mid-stream
      wait_valid("wait_valid_reset");
      reset = 1'b1;
      tick(); settle();
      chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
      chk("midrst_rd_en", 32'(bus.mem_rd_en), 32'd0);
      tick(); reset = 1'b0;
      settle();
      chk("restart_rd_en", 32'(bus.mem_rd_en), 32'd1);
      chk("restart_addr", 32'(bus.mem_addr), 32'h0000);
      tick(); tick(); settle();
      chk("restart_valid", 32'(bus.instr_valid), 32'd1);
      chk("restart_pc", 32'(bus.instr_pc), 32'h0000);
      run(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
